// File: rtl/uart_core_p.sv
`timescale 1ns/1ps
// uart_core_p: parametrised full-duplex UART (one TX, one RX) with
// ready/valid transmit handshake, mid-bit receive sampling, false-start
// rejection and framing-error reporting.
// Optional parity bit: define UART_PARITY_EN (PARITY_ODD selects odd parity).
module uart_core_p #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_tx,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

    // Counter must span the whole stop phase, which may be two bit periods.
    localparam int unsigned CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

    // Reject parameter values the bit timing cannot support.
    if ((CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0) ||
        (DATA_BITS < 5) || (DATA_BITS > 9) ||
        (STOP_BITS < 1) || (STOP_BITS > 2) || (PARITY_ODD > 1)) begin : g_param_check
        $error("uart_core_p: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_e              tx_state_q, tx_state_d;
    logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]       tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   uart_tx_q, uart_tx_d;
    logic                   tx_ready_q, tx_ready_d;
`ifdef UART_PARITY_EN
    logic                   tx_par_q, tx_par_d;
`endif

    // TX state and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            uart_tx_q  <= 1'b1;
            tx_ready_q <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            uart_tx_q  <= uart_tx_d;
            tx_ready_q <= tx_ready_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // TX next state: the line level for the next cycle is decided here so
    // uart_tx leaves a flop and changes exactly on bit boundaries.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        uart_tx_d  = uart_tx_q;
        tx_ready_d = tx_ready_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        unique case (tx_state_q)
            TX_IDLE: begin
                uart_tx_d  = 1'b1;
                tx_ready_d = 1'b1;
                if (tx_valid && tx_ready_q) begin
                    tx_shift_d = tx_data;
`ifdef UART_PARITY_EN
                    tx_par_d   = (^tx_data) ^ 1'(PARITY_ODD);
`endif
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_ready_d = 1'b0;
                    uart_tx_d  = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    uart_tx_d  = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == DATA_LAST) begin
`ifdef UART_PARITY_EN
                        uart_tx_d  = tx_par_q;
                        tx_state_d = TX_PARITY;
`else
                        uart_tx_d  = 1'b1;
                        tx_state_d = TX_STOP;
`endif
                    end else begin
                        tx_bit_d   = tx_bit_q + BIT_W'(1);
                        tx_shift_d = tx_shift_q >> 1;
                        uart_tx_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    uart_tx_d  = 1'b1;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
`endif
            TX_STOP: begin
                if (tx_cnt_q == STOP_LAST) begin
                    tx_cnt_d   = '0;
                    uart_tx_d  = 1'b1;
                    tx_ready_d = 1'b1;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                uart_tx_d  = 1'b1;
                tx_ready_d = 1'b1;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]             rx_sync_q;
    logic                   rx_line;
    rx_state_e              rx_state_q, rx_state_d;
    logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]       rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_ferr_q, rx_ferr_d;
`ifdef UART_PARITY_EN
    logic                   rx_par_bad_q, rx_par_bad_d;
    logic                   rx_perr_q, rx_perr_d;
`endif

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], uart_rx};
        end
    end

    assign rx_line = rx_sync_q[1];

    // RX state and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_ferr_q    <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad_q <= 1'b0;
            rx_perr_q    <= 1'b0;
`endif
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_ferr_q    <= rx_ferr_d;
`ifdef UART_PARITY_EN
            rx_par_bad_q <= rx_par_bad_d;
            rx_perr_q    <= rx_perr_d;
`endif
        end
    end

    // RX next state: half a bit into the start bit, then every full bit,
    // lands each sample in the middle of its bit.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_ferr_d    = rx_ferr_q;
`ifdef UART_PARITY_EN
        rx_par_bad_d = rx_par_bad_q;
        rx_perr_d    = rx_perr_q;
`endif
        unique case (rx_state_q)
            RX_IDLE: begin
                if (!rx_line) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // A line already back high mid-start-bit is a glitch.
                    rx_state_d = rx_line ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_line, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_W'(1);
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d     = '0;
                    rx_par_bad_d = rx_line ^ (^rx_shift_q) ^ 1'(PARITY_ODD);
                    rx_state_d   = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    rx_ferr_d  = !rx_line;
`ifdef UART_PARITY_EN
                    rx_perr_d  = rx_par_bad_q;
`endif
                    // A low stop bit may be a break; wait for idle before rearming.
                    rx_state_d = rx_line ? RX_IDLE : RX_WAIT_HIGH;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_line) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    assign tx_ready     = tx_ready_q;
    assign uart_tx      = uart_tx_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_ferr_q;
`ifdef UART_PARITY_EN
    assign rx_parity_err = rx_perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core_p.sv
`timescale 1ns/1ps
// tb_uart_core_p: directed bench with a frame-level reference model for the
// transmitter and a scoreboard of expected received words.
module tb_uart_core_p;

    localparam int unsigned CPB  = 16;
    localparam int unsigned DB   = 8;
    localparam int unsigned SB   = 1;
    localparam int unsigned PODD = 0;
`ifdef UART_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif
    localparam int unsigned FRAME = (1 + DB + PB + SB) * CPB;
    localparam int unsigned TR_N  = FRAME + 8;

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       uart_tx;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_drv;
    logic       loop_en;

    uart_core_p #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .STOP_BITS   (SB),
        .PARITY_ODD  (PODD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .uart_tx      (uart_tx),
        .uart_rx      (uart_rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_parity_err(rx_parity_err)
    );

    assign uart_rx = loop_en ? uart_tx : rx_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rx_pulses = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } rx_exp_t;

    rx_exp_t    exp_q[$];
    rx_exp_t    e_cur;
    logic [7:0] last_data;

    logic       tr[TR_N];
    int         tr_low;
    time        t_acc;

    task automatic fail(input string msg);
        n_fail++;
        if (n_fail <= 40) $display("FAIL %s", msg);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) fail($sformatf("%s: got %0h, required %0h", name, act, req));
    endtask

    function automatic rx_exp_t mk(input logic [7:0] d, input logic fe, input logic pe);
        rx_exp_t r;
        r.d  = d;
        r.fe = fe;
        r.pe = pe;
        return r;
    endfunction

    // Line level c cycles into a frame carrying word w (c=0 is the first cycle after accept).
    function automatic logic wire_bit(input logic [7:0] w, input int unsigned c);
        int unsigned idx;
        idx = c / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= DB) return w[idx-1];
        if ((PB == 1) && (idx == DB + 1)) return (^w) ^ 1'(PODD);
        return 1'b1;
    endfunction

    // Transmitter reference: busy for exactly FRAME cycles after each accept.
    logic        m_busy;
    int unsigned m_k;
    logic [7:0]  m_word;
    logic        exp_tx;
    logic        exp_rdy;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0;
            m_k    <= 0;
            m_word <= 8'h00;
        end else if (m_busy) begin
            if (m_k == FRAME - 1) m_busy <= 1'b0;
            m_k <= m_k + 1;
        end else if (tx_valid) begin
            m_busy <= 1'b1;
            m_k    <= 0;
            m_word <= tx_data;
        end
    end

    always_comb begin
        exp_tx  = 1'b1;
        exp_rdy = 1'b1;
        if (m_busy) begin
            exp_tx  = wire_bit(m_word, m_k);
            exp_rdy = 1'b0;
        end
    end

    // Per-cycle compare of DUT outputs against model and scoreboard.
    initial begin
        last_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                n_tests++;
                if (uart_tx !== 1'b1 || tx_ready !== 1'b1 || rx_valid !== 1'b0 ||
                    rx_data !== 8'h00 || rx_frame_err !== 1'b0 || rx_parity_err !== 1'b0)
                    fail($sformatf("reset_outputs: tx=%b rdy=%b rv=%b rd=%h fe=%b pe=%b, required 1 1 0 00 0 0",
                                   uart_tx, tx_ready, rx_valid, rx_data, rx_frame_err, rx_parity_err));
                last_data = 8'h00;
            end else begin
                n_tests++;
                if (uart_tx !== exp_tx || tx_ready !== exp_rdy)
                    fail($sformatf("tx_model at %0t: tx=%b rdy=%b, required tx=%b rdy=%b",
                                   $time, uart_tx, tx_ready, exp_tx, exp_rdy));
                n_tests++;
                if (rx_valid === 1'b1) begin
                    rx_pulses++;
                    if (exp_q.size() == 0) begin
                        fail($sformatf("rx_unexpected at %0t: rx_valid=1 rd=%h, required no pulse", $time, rx_data));
                    end else begin
                        e_cur = exp_q.pop_front();
                        last_data = e_cur.d;
                        if (rx_data !== e_cur.d || rx_frame_err !== e_cur.fe || rx_parity_err !== e_cur.pe)
                            fail($sformatf("rx_word at %0t: rd=%h fe=%b pe=%b, required %h %b %b",
                                           $time, rx_data, rx_frame_err, rx_parity_err, e_cur.d, e_cur.fe, e_cur.pe));
                    end
                end else if (rx_valid !== 1'b0 || rx_data !== last_data) begin
                    fail($sformatf("rx_hold at %0t: rv=%b rd=%h, required 0 %h", $time, rx_valid, rx_data, last_data));
                end
            end
        end
    end

    // Offer a word and return right after the accepting edge.
    task automatic tx_offer(input logic [7:0] d, input bit push_rx);
        int w;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        w = 0;
        while (tx_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (tx_ready !== 1'b1) begin
            n_tests++;
            fail($sformatf("tx_accept_timeout: tx_ready=%b, required 1", tx_ready));
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        t_acc = $time;
        if (push_rx) exp_q.push_back(mk(d, 1'b0, 1'b0));
    endtask

    task automatic send_tx(input logic [7:0] d, input bit push_rx);
        tx_offer(d, push_rx);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    // Send a word and record the line and tx_ready for TR_N cycles.
    task automatic send_capture(input logic [7:0] d);
        tx_offer(d, 1'b0);
        tr_low = 0;
        for (int i = 0; i < int'(TR_N); i++) begin
            @(negedge clk);
            if (i == 0) begin
                tx_valid = 1'b0;
                tx_data  = ~d;
            end
            tr[i] = uart_tx;
            if (tx_ready === 1'b0) tr_low++;
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        rx_drv = b;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic inject(input logic [7:0] d, input logic stop_v, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < int'(DB); i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
        drive_bit((^d) ^ 1'(PODD) ^ par_flip);
`else
        if (par_flip) $display("[TB] note: no parity bit in this build");
`endif
        drive_bit(stop_v);
    endtask

    task automatic wait_rx_drain(input string name, input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        n_tests++;
        if (exp_q.size() != 0)
            fail($sformatf("%s: %0d expected words never arrived, required 0", name, exp_q.size()));
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   p0;
        time  t1;
        int   zeros;
        int   pat55[8];
        pat55 = '{1, 0, 1, 0, 1, 0, 1, 0};

        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_drv   = 1'b1;
        loop_en  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_state", 32'({uart_tx, tx_ready, rx_valid, rx_frame_err, rx_parity_err, rx_data}),
              32'({5'b11000, 8'h00}));

        // Reset in the middle of a transmit.
        send_tx(8'h81, 1'b0);
        repeat (40) @(negedge clk);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("midframe_reset_uart_tx", 32'(uart_tx), 32'd1);
        check("midframe_reset_tx_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        p0 = rx_pulses;
        repeat (50) @(negedge clk);
        check("idle_no_rx_valid", 32'(rx_pulses - p0), 32'd0);

        // 0x55 waveform, pinned with hand-derived values.
        send_capture(8'h55);
        zeros = 0;
        for (int i = 0; i < 16; i++) if (tr[i] === 1'b0) zeros++;
        check("tx55_start_low_cycles", 32'(zeros), 32'd16);
        for (int k = 0; k < 8; k++)
            check($sformatf("tx55_bit%0d", k), 32'(tr[16 * (k + 1) + 8]), 32'(pat55[k]));
`ifdef UART_PARITY_EN
        check("tx55_parity", 32'(tr[152]), 32'd0);
        check("tx55_stop", 32'(tr[168]), 32'd1);
        check("tx55_ready_low", 32'(tr_low), 32'd176);
`else
        check("tx55_stop", 32'(tr[152]), 32'd1);
        check("tx55_ready_low", 32'(tr_low), 32'd160);
`endif

        // Loopback, back-to-back words; data changes after accept must be ignored.
        loop_en = 1'b1;
        p0 = rx_pulses;
        send_tx(8'h00, 1'b1);
        send_tx(8'hFF, 1'b1);
        t1 = t_acc;
        send_tx(8'hA5, 1'b1);
        check("b2b_accept_gap", 32'((t_acc - t1) / 10), 32'(FRAME + 1));
        wait_rx_drain("loopback_drain", 3 * int'(FRAME));
        check("loopback_pulses", 32'(rx_pulses - p0), 32'd3);
        repeat (2 * CPB) @(negedge clk);
        loop_en = 1'b0;

        // Short glitch is rejected; a proper frame afterwards is received.
        p0 = rx_pulses;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (CPB) @(negedge clk);
        check("glitch_no_rx_valid", 32'(rx_pulses - p0), 32'd0);
        exp_q.push_back(mk(8'h3C, 1'b0, 1'b0));
        inject(8'h3C, 1'b1, 1'b0);
        wait_rx_drain("after_glitch_drain", 4 * int'(CPB));
        check("after_glitch_pulses", 32'(rx_pulses - p0), 32'd1);

        // Framing error, line held low (break), then recovery.
        repeat (2 * CPB) @(negedge clk);
        p0 = rx_pulses;
        exp_q.push_back(mk(8'h3C, 1'b1, 1'b0));
        inject(8'h3C, 1'b0, 1'b0);
        repeat (5 * CPB) @(negedge clk);
        wait_rx_drain("frame_err_drain", 4 * int'(CPB));
        check("break_single_pulse", 32'(rx_pulses - p0), 32'd1);
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        exp_q.push_back(mk(8'h12, 1'b0, 1'b0));
        inject(8'h12, 1'b1, 1'b0);
        wait_rx_drain("recover_drain", 4 * int'(CPB));
        check("recover_pulses", 32'(rx_pulses - p0), 32'd2);

`ifdef UART_PARITY_EN
        // Even parity of 0x07 is 1; an injected wrong parity is flagged.
        repeat (2 * CPB) @(negedge clk);
        send_capture(8'h07);
        check("tx07_parity_bit", 32'(tr[152]), 32'd1);
        p0 = rx_pulses;
        exp_q.push_back(mk(8'h07, 1'b0, 1'b1));
        inject(8'h07, 1'b1, 1'b1);
        wait_rx_drain("parity_err_drain", 4 * int'(CPB));
        check("parity_err_pulses", 32'(rx_pulses - p0), 32'd1);
`endif

        repeat (2 * CPB) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
